// File: rtl/div_tick_timer_if.sv
// Handshake bundle for div_tick_timer: divided-clock bus, tap select,
// start/pause controls in; tick, hour, running, day_done out.
// master: drives controls (testbench / upstream); slave: the timer.
// With STEP_BUTTON_EN defined the bundle also carries the step input.
interface div_tick_timer_if;
   logic [31:0] divided_clocks;
   logic [4:0]  tap_sel;
   logic        start;
   logic        pause;
`ifdef STEP_BUTTON_EN
   logic        step;
`endif
   logic        tick;
   logic [2:0]  hour;
   logic        running;
   logic        day_done;

   modport master (
`ifdef STEP_BUTTON_EN
      output step,
`endif
      output divided_clocks, tap_sel, start, pause,
      input  tick, hour, running, day_done
   );

   modport slave (
`ifdef STEP_BUTTON_EN
      input  step,
`endif
      input  divided_clocks, tap_sel, start, pause,
      output tick, hour, running, day_done
   );
endinterface

// File: rtl/div_tick_timer.sv
// div_tick_timer: picks one divided-clock bit as a time base, emits a
// one-cycle tick per rising edge of it, and counts HOURS (2..8) ticks
// per simulated day under an IDLE/RUN/PAUSED/DONE state machine.
// Ports: clock, reset (sync, active high); bus (div_tick_timer_if.slave)
//   in : divided_clocks[31:0], tap_sel[4:0], start, pause (step)
//   out: tick, hour[2:0], running, day_done
// Optional macro STEP_BUTTON_EN adds a step input that also makes ticks.
module div_tick_timer #(
   parameter int HOURS = 8
) (
   input logic             clock,
   input logic             reset,
   div_tick_timer_if.slave bus
);

   localparam logic [2:0] LAST = 3'(HOURS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSED,
      S_DONE
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_hour;
   logic [2:0] w_hour_nxt;
   logic       r_tap_q;
   logic [4:0] r_tap_sel_q;
   logic       r_tick;
   logic       w_tap;
   logic       w_edge;

   assign w_tap = bus.divided_clocks[bus.tap_sel];

`ifdef STEP_BUTTON_EN
   logic r_step_q;
   logic w_step_edge;

   assign w_step_edge = bus.step & ~r_step_q;

   always_ff @(posedge clock) begin
      if (reset) r_step_q <= 1'b0;
      else       r_step_q <= bus.step;
   end

   // A tap edge on the cycle tap_sel moves is bogus; step is not.
   assign w_edge = (w_tap & ~r_tap_q & (bus.tap_sel == r_tap_sel_q))
                 | w_step_edge;
`else
   assign w_edge = w_tap & ~r_tap_q & (bus.tap_sel == r_tap_sel_q);
`endif

   // tap_sel_q follows tap_sel even in reset, so the first
   // post-reset cycle is not mistaken for a tap switch.
   always_ff @(posedge clock) begin
      r_tap_sel_q <= bus.tap_sel;
      if (reset) begin
         r_tap_q <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_tap_q <= w_tap;
         r_tick  <= w_edge;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_hour  <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_hour  <= w_hour_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hour_nxt  = r_hour;
      unique case (r_state)
         S_IDLE: begin
            w_hour_nxt = 3'd0;
            if (bus.start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            // The last tick of the day beats a coincident pause.
            if (r_tick && (r_hour == LAST)) begin
               w_state_nxt = S_DONE;
            end else begin
               if (r_tick)    w_hour_nxt  = r_hour + 3'd1;
               if (bus.pause) w_state_nxt = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (bus.start && !bus.pause) w_state_nxt = S_RUN;
         end
         S_DONE: begin
            if (bus.start) begin
               w_state_nxt = S_RUN;
               w_hour_nxt  = 3'd0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_hour_nxt  = 3'd0;
         end
      endcase
   end

   assign bus.tick     = r_tick;
   assign bus.hour     = r_hour;
   assign bus.running  = (r_state == S_RUN);
   assign bus.day_done = (r_state == S_DONE);

endmodule

// File: tb/tb_div_tick_timer.sv
// Self-checking bench for div_tick_timer: directed vector table plus
// tick-period and optional step-button sequences.
module tb_div_tick_timer;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   div_tick_timer_if bus ();

   div_tick_timer #(.HOURS(8)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [4:0]  sel;
      logic [31:0] d;
      logic        st;
      logic        pa;
      logic        t;
      logic [2:0]  h;
      logic        r;
      logic        dn;
   } vec_t;

   vec_t vq[$];

   function automatic void addv(
      input logic rs, input logic [4:0] sl, input logic [31:0] dd,
      input logic s, input logic p, input logic t, input logic [2:0] h,
      input logic r, input logic dn);
      vec_t v;
      v.rst = rs; v.sel = sl; v.d = dd; v.st = s; v.pa = p;
      v.t = t; v.h = h; v.r = r; v.dn = dn;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input int idx,
                      input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %0d expected %0d",
                  nm, idx, act, exp);
      end
   endtask

   int tk[$];
   int cyc;
   int nt;
   int per;

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.divided_clocks = '0;
      bus.tap_sel = '0;
      bus.start = 1'b0;
      bus.pause = 1'b0;
`ifdef STEP_BUTTON_EN
      bus.step = 1'b0;
`endif

      // reset, then start one cycle after reset
      addv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 0, 0, 1, 0, 0, 0, 1, 0);
      // 8 ticks on tap 0: hour 0..7, then DONE
      for (int k = 0; k < 7; k++) begin
         addv(0, 0, 1, 0, 0, 1, 3'(k), 1, 0);
         addv(0, 0, 0, 0, 0, 0, 3'(k + 1), 1, 0);
      end
      addv(0, 0, 1, 0, 0, 1, 7, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 7, 0, 1);
      // DONE: pause ignored, start restarts at hour 0
      addv(0, 0, 1, 0, 1, 1, 7, 0, 1);
      addv(0, 0, 0, 1, 0, 0, 0, 1, 0);
      addv(0, 0, 1, 0, 0, 1, 0, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 1, 1, 0);
      addv(0, 0, 1, 0, 0, 1, 1, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 2, 1, 0);
      // hour 2: tick and pause coincide -> hour 3, PAUSED
      addv(0, 0, 1, 0, 0, 1, 2, 1, 0);
      addv(0, 0, 0, 0, 1, 0, 3, 0, 0);
      for (int k = 0; k < 4; k++) begin
         addv(0, 0, 1, 0, 0, 1, 3, 0, 0);
         addv(0, 0, 0, 0, 0, 0, 3, 0, 0);
      end
      // start+pause stays paused; start alone resumes
      addv(0, 0, 0, 1, 1, 0, 3, 0, 0);
      addv(0, 0, 0, 1, 0, 0, 3, 1, 0);
      addv(0, 0, 1, 0, 0, 1, 3, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 4, 1, 0);
      // tap switch 3 -> 0 with tap3=0, tap0=1: no tick
      addv(0, 3, 0, 0, 0, 0, 4, 1, 0);
      addv(0, 3, 0, 0, 0, 0, 4, 1, 0);
      addv(0, 0, 1, 0, 0, 0, 4, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 4, 1, 0);
      addv(0, 0, 1, 0, 0, 1, 4, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 5, 1, 0);
      // reset at hour 5 while edge_det is true
      addv(1, 0, 1, 0, 0, 0, 0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 1, 0, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // higher taps select the right bit
      addv(0, 5, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 5, 32'h20, 0, 0, 1, 0, 0, 0);
      addv(0, 5, 32'h1F, 0, 0, 0, 0, 0, 0);
      addv(0, 31, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 31, 32'h8000_0000, 0, 0, 1, 0, 0, 0);
      addv(0, 31, 32'h8000_0000, 0, 0, 0, 0, 0, 0);

      foreach (vq[i]) begin
         @(negedge clk);
         rst = vq[i].rst;
         bus.tap_sel = vq[i].sel;
         bus.divided_clocks = vq[i].d;
         bus.start = vq[i].st;
         bus.pause = vq[i].pa;
         @(posedge clk);
         #1;
         chk("tick", i, int'(bus.tick), int'(vq[i].t));
         chk("hour", i, int'(bus.hour), int'(vq[i].h));
         chk("running", i, int'(bus.running), int'(vq[i].r));
         chk("day_done", i, int'(bus.day_done), int'(vq[i].dn));
      end

      // free-running divider: tick period must be 2^(n+1)
      cyc = 0;
      for (int n = 0; n < 4; n++) begin
         per = 2 << n;
         tk.delete();
         for (int c = 0; c < 6 * per + 4; c++) begin
            @(negedge clk);
            rst = 1'b0;
            bus.tap_sel = 5'(n);
            bus.divided_clocks = 32'(cyc);
            cyc++;
            @(posedge clk);
            #1;
            if (bus.tick) tk.push_back(c);
         end
         chk("tick_count_ok", n, int'(tk.size() >= 4), 1);
         if (tk.size() >= 4)
            for (int j = 1; j < 4; j++)
               chk("tick_period", n, tk[j] - tk[j-1], per);
      end

`ifdef STEP_BUTTON_EN
      // tap 31 never rises here: only step presses make ticks
      @(negedge clk);
      rst = 1'b1;
      bus.tap_sel = 5'd31;
      bus.divided_clocks = '0;
      bus.step = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      nt = 0;
      for (int c = 0; c < 18; c++) begin
         bus.step = ((c % 6) < 2) && (c < 18);
         @(posedge clk);
         #1;
         if (bus.tick) nt++;
         if (bus.tick && c > 0) chk("step_width", c, 0, 0);
         @(negedge clk);
      end
      bus.step = 1'b0;
      @(posedge clk);
      #1;
      if (bus.tick) nt++;
      @(negedge clk);
      chk("step_ticks", 0, nt, 3);
      chk("step_hour", 0, int'(bus.hour), 3);
      chk("step_running", 0, int'(bus.running), 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_tick_timer.md
DIV_TICK_TIMER -- requirements
Module: div_tick_timer

Interface
REQ-001 Parameter: HOURS, default 8, number of simulated hours per day; legal range 2..8.
REQ-002 Port: clock, input, 1, single system clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, synchronous active-high reset.
REQ-004 Port: divided_clocks, input, 32, free-running divided-clock bus from the upstream clock divider (bit n toggles every 2^n clock cycles).
REQ-005 Port: tap_sel, input, 5, index of the divided_clocks bit used as the time base.
REQ-006 Port: start, input, 1, level; starts counting from IDLE, resumes from PAUSED, restarts from DONE.
REQ-007 Port: pause, input, 1, level; suspends counting while in RUN.
REQ-008 Port: tick, output, 1, one-cycle pulse per rising edge of the selected tap.
REQ-009 Port: hour, output, 3, current hour count, 0..HOURS-1.
REQ-010 Port: running, output, 1, high exactly while the FSM is in RUN.
REQ-011 Port: day_done, output, 1, high exactly while the FSM is in DONE.

Function
REQ-012 Tap path: tap = divided_clocks[tap_sel]; tap_q and tap_sel_q shall be registered every cycle.
REQ-013 Edge: edge_det = tap & ~tap_q & (tap_sel == tap_sel_q); tick shall be the registered edge_det, so it is high for exactly one cycle, one cycle after the cycle in which edge_det is true.
REQ-014 tap_sel change: no tick shall result from the cycle in which tap_sel differs from tap_sel_q, which prevents spurious edges on a tap switch.
REQ-015 tap_sel = 0: tick shall pulse every 2 cycles; tap_sel = n: one tick every 2^(n+1) cycles.
REQ-016 tick shall run in every FSM state; only hour counting is gated by the FSM.
REQ-017 FSM states are IDLE, RUN, PAUSED and DONE.
REQ-018 IDLE: hour = 0; start shall go to RUN.
REQ-019 RUN: on tick, if hour < HOURS-1, hour shall increment by 1; if hour == HOURS-1, hour shall hold and the FSM shall go to DONE.
REQ-020 RUN: pause shall go to PAUSED; a tick in the same cycle shall still be counted (or trigger DONE, in which case DONE wins over PAUSED).
REQ-021 PAUSED: hour shall hold and ticks shall be ignored; start shall go to RUN; if start and pause are both high, the FSM shall stay in PAUSED.
REQ-022 DONE: hour shall hold at HOURS-1; start shall go to RUN with hour = 0 on the same edge; pause shall be ignored.
REQ-023 Width: hour shall be 3 bits, zero-extended when HOURS < 8, and shall never exceed HOURS-1 or wrap.

Reset
REQ-024 While reset is high at a rising clock edge: state = IDLE, hour = 0, tick = 0, tap_q = 0, tap_sel_q = tap_sel, running = 0, day_done = 0.
REQ-025 Reset shall take priority over start, pause and tick; assertion mid-RUN shall abort counting with no residual tick in the following cycle.

Configuration
REQ-026 Macro: STEP_BUTTON_EN.
REQ-027 When STEP_BUTTON_EN is defined, an input port step (1 bit, already synchronized, level) shall exist; the rising edge of step, detected through its own register, shall be ORed into edge_det, with the same one-cycle tick latency; coincident tap and step edges shall give one tick.
REQ-028 When STEP_BUTTON_EN is undefined, the step port shall not exist and tick shall derive only from the tap.

Verification
REQ-029 tap_sel=0, start pulsed one cycle after reset -> tick every 2 cycles; hour 0→7 after 7 ticks; DONE (day_done=1, running=0) on the 8th tick, hour held at 7.
REQ-030 tap_sel switched 3→0 while tap 3 = 0 and tap 0 = 1 -> no tick in the cycle following the switch; normal ticks resume afterwards.
REQ-031 In RUN at hour=2, pause and tick coincide -> hour=3, state PAUSED; 4 further ticks leave hour=3; start -> running=1, next tick gives hour=4.
REQ-032 In DONE, assert start -> next cycle running=1, hour=0, day_done=0; pause in DONE has no effect.
REQ-033 reset asserted mid-RUN at hour=5 while edge_det is true -> next cycle hour=0, tick=0, IDLE; ticks resume only on later tap edges.
REQ-034 With STEP_BUTTON_EN, tap_sel=31, step pulsed 3 times in RUN -> exactly 3 one-cycle ticks, hour=3.
